// File: rtl/seq_datapath.sv
// seq_datapath: register file, A/B operand registers, shifter, ALU, result C and Z/N/V
// status, driven by a micro-sequencer (IDLE -> LA -> LB -> EX -> WB) per command.
`default_nettype none

module seq_datapath #(
    parameter int WIDTH  = 16,
    parameter int NREGS  = 8,
    parameter int IMM_W  = 8,
    localparam int RW    = $clog2(NREGS)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       mode,
    input  logic [RW-1:0]    rd,
    input  logic [RW-1:0]    rn,
    input  logic [RW-1:0]    rm,
    input  logic [1:0]       shift,
    input  logic [1:0]       aluop,
    input  logic [IMM_W-1:0] imm,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] datapath_out,
    output logic             Z_out,
    output logic             N_out,
    output logic             V_out,
    input  logic [RW-1:0]    dbg_addr,
    output logic [WIDTH-1:0] dbg_data
);

    localparam logic [2:0] c_IDLE = 3'd0;
    localparam logic [2:0] c_LA   = 3'd1;
    localparam logic [2:0] c_LB   = 3'd2;
    localparam logic [2:0] c_EX   = 3'd3;
    localparam logic [2:0] c_WB   = 3'd4;

    localparam logic [1:0] c_MODE_ALU  = 2'b00;
    localparam logic [1:0] c_MODE_CMP  = 2'b01;
    localparam logic [1:0] c_MODE_MOVI = 2'b10;
    localparam logic [1:0] c_MODE_MOV  = 2'b11;

    localparam logic [1:0] c_SH_NONE = 2'b00;
    localparam logic [1:0] c_SH_LSL  = 2'b01;
    localparam logic [1:0] c_SH_LSR  = 2'b10;

    localparam logic [1:0] c_OP_ADD = 2'b00;
    localparam logic [1:0] c_OP_SUB = 2'b01;
    localparam logic [1:0] c_OP_AND = 2'b10;

    localparam int c_MSB = WIDTH - 1;

    logic [2:0]       r_state;
    logic [1:0]       r_mode;
    logic [RW-1:0]    r_rd;
    logic [RW-1:0]    r_rn;
    logic [RW-1:0]    r_rm;
    logic [1:0]       r_shift;
    logic [1:0]       r_aluop;
    logic [IMM_W-1:0] r_imm;

    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_c;
    logic             r_z;
    logic             r_n;
    logic             r_v;
    logic [WIDTH-1:0] r_regs [NREGS];

    logic [WIDTH-1:0] w_bsh;
    logic [WIDTH-1:0] w_alu;
    logic             w_v;
    logic [WIDTH-1:0] w_sext;

    generate
        if (IMM_W < WIDTH) begin : g_sext_pad
            assign w_sext = {{(WIDTH-IMM_W){r_imm[IMM_W-1]}}, r_imm};
        end else begin : g_sext_full
            assign w_sext = r_imm;
        end
    endgenerate

    always_comb begin
        w_bsh = r_b;
        case (r_shift)
            c_SH_NONE: w_bsh = r_b;
            c_SH_LSL:  w_bsh = {r_b[c_MSB-1:0], 1'b0};
            c_SH_LSR:  w_bsh = {1'b0, r_b[c_MSB:1]};
            default:   w_bsh = {r_b[c_MSB], r_b[c_MSB:1]};
        endcase
    end

    // Overflow is judged on the shifted B operand, the value the ALU actually sees.
    always_comb begin
        w_alu = '0;
        w_v   = 1'b0;
        case (r_aluop)
            c_OP_ADD: begin
                w_alu = r_a + w_bsh;
                w_v   = (r_a[c_MSB] == w_bsh[c_MSB]) && (w_alu[c_MSB] != r_a[c_MSB]);
            end
            c_OP_SUB: begin
                w_alu = r_a - w_bsh;
                w_v   = (r_a[c_MSB] != w_bsh[c_MSB]) && (w_alu[c_MSB] != r_a[c_MSB]);
            end
            c_OP_AND: begin
                w_alu = r_a & w_bsh;
                w_v   = 1'b0;
            end
            default: begin
                w_alu = ~w_bsh;
                w_v   = 1'b0;
            end
        endcase
    end

    // Sequencer and command latch; fields only change on an accepted start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_IDLE;
            r_mode  <= '0;
            r_rd    <= '0;
            r_rn    <= '0;
            r_rm    <= '0;
            r_shift <= '0;
            r_aluop <= '0;
            r_imm   <= '0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (start) begin
                        r_mode  <= mode;
                        r_rd    <= rd;
                        r_rn    <= rn;
                        r_rm    <= rm;
                        r_shift <= shift;
                        r_aluop <= aluop;
                        r_imm   <= imm;
                        if (mode == c_MODE_MOVI) begin
                            r_state <= c_EX;
                        end else if (mode == c_MODE_MOV) begin
                            r_state <= c_LB;
                        end else begin
                            r_state <= c_LA;
                        end
                    end
                end
                c_LA:    r_state <= c_LB;
                c_LB:    r_state <= c_EX;
                c_EX:    r_state <= c_WB;
                default: r_state <= c_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a <= '0;
            r_b <= '0;
            r_c <= '0;
            r_z <= 1'b0;
            r_n <= 1'b0;
            r_v <= 1'b0;
        end else begin
            if (r_state == c_LA) begin
                r_a <= r_regs[r_rn];
            end
            if (r_state == c_LB) begin
                r_b <= r_regs[r_rm];
            end
            if (r_state == c_EX) begin
                case (r_mode)
                    c_MODE_MOVI: r_c <= w_sext;
                    c_MODE_MOV:  r_c <= w_bsh;
                    default: begin
                        r_c <= w_alu;
                        r_z <= (w_alu == '0);
                        r_n <= w_alu[c_MSB];
                        r_v <= w_v;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                r_regs[i] <= '0;
            end
        end else if ((r_state == c_WB) && (r_mode != c_MODE_CMP)) begin
            r_regs[r_rd] <= r_c;
        end
    end

    assign busy         = (r_state != c_IDLE);
    assign done         = (r_state == c_WB);
    assign datapath_out = r_c;
    assign Z_out        = r_z;
    assign N_out        = r_n;
    assign V_out        = r_v;
    assign dbg_data     = r_regs[dbg_addr];

endmodule

`default_nettype wire

// File: tb/tb_seq_datapath.sv
// Scoreboard bench for seq_datapath: stimulus pushes model results, a monitor checks on done.
`default_nettype none

module tb_seq_datapath;

    localparam int W  = 16;
    localparam int NR = 8;
    localparam int IW = 8;
    localparam int RW = $clog2(NR);
    localparam longint MOD = 64'sd1 <<< W;
    localparam longint SMAX = (64'sd1 <<< (W-1)) - 1;
    localparam longint SMIN = -(64'sd1 <<< (W-1));

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic [1:0]    mode;
    logic [RW-1:0] rd, rn, rm;
    logic [1:0]    shift, aluop;
    logic [IW-1:0] imm;
    logic          busy, done;
    logic [W-1:0]  datapath_out;
    logic          Z_out, N_out, V_out;
    logic [RW-1:0] dbg_addr;
    logic [W-1:0]  dbg_data;

    seq_datapath #(.WIDTH(W), .NREGS(NR), .IMM_W(IW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .rd(rd), .rn(rn),
        .rm(rm), .shift(shift), .aluop(aluop), .imm(imm), .busy(busy), .done(done),
        .datapath_out(datapath_out), .Z_out(Z_out), .N_out(N_out), .V_out(V_out),
        .dbg_addr(dbg_addr), .dbg_data(dbg_data)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    typedef struct {
        logic [W-1:0] c;
        logic         z, n, v;
        int           rd;
        logic [W-1:0] rdval;
        int           dcyc;
    } exp_t;

    exp_t         q[$];
    logic [W-1:0] m_r [NR];
    logic         m_z, m_n, m_v;
    int           errors = 0;
    int           checks = 0;

    task automatic check(input string name, input longint act, input longint req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic longint sval(input logic [W-1:0] x);
        return x[W-1] ? longint'(x) - MOD : longint'(x);
    endfunction

    function automatic logic [W-1:0] wrap(input longint x);
        longint m;
        m = x % MOD;
        if (m < 0) m += MOD;
        return m[W-1:0];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NR; i++) m_r[i] = '0;
        m_z = 0; m_n = 0; m_v = 0;
    endtask

    task automatic randomize_inputs();
        mode  = 2'($urandom);
        rd    = RW'($urandom);
        rn    = RW'($urandom);
        rm    = RW'($urandom);
        shift = 2'($urandom);
        aluop = 2'($urandom);
        imm   = IW'($urandom);
    endtask

    task automatic wait_idle(input string name);
        int t = 0;
        while (busy && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (busy) check(name, 1, 0);
    endtask

    // Reference: operand values from the model register array, arithmetic on signed integers.
    task automatic issue(input int md, input int d, input int n, input int m,
                         input int sh, input int op, input int im, input bit poke);
        longint       sb, s, si;
        logic [W-1:0] bs, res;
        bit           v;
        exp_t         e;
        wait_idle("idle_wait");
        sb = sval(m_r[m]);
        case (sh)
            0: bs = m_r[m];
            1: bs = wrap(longint'(m_r[m]) * 2);
            2: bs = wrap(longint'(m_r[m]) / 2);
            default: bs = wrap((sb < 0) ? (sb - 1) / 2 : sb / 2);
        endcase
        v = 0;
        if (md == 2) begin
            si = (im >= (1 << (IW-1))) ? longint'(im) - (64'sd1 <<< IW) : longint'(im);
            res = wrap(si);
        end else if (md == 3) begin
            res = bs;
        end else begin
            case (op)
                0: begin s = sval(m_r[n]) + sval(bs); v = (s > SMAX) || (s < SMIN); res = wrap(s); end
                1: begin s = sval(m_r[n]) - sval(bs); v = (s > SMAX) || (s < SMIN); res = wrap(s); end
                2: res = m_r[n] & bs;
                default: res = ~bs;
            endcase
            m_z = (res == 0);
            m_n = (sval(res) < 0);
            m_v = v;
        end
        if (md != 1) m_r[d] = res;
        e.c = res; e.z = m_z; e.n = m_n; e.v = m_v;
        e.rd = d; e.rdval = m_r[d];
        e.dcyc = cyc + ((md == 2) ? 2 : (md == 3) ? 3 : 4);
        q.push_back(e);
        mode = 2'(md); rd = RW'(d); rn = RW'(n); rm = RW'(m);
        shift = 2'(sh); aluop = 2'(op); imm = IW'(im);
        start = 1'b1;
        @(negedge clk);
        start = poke;
        randomize_inputs();
        @(negedge clk);
        start = 1'b0;
        randomize_inputs();
        wait_idle("done_wait");
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && done) begin
                if (q.size() == 0) begin
                    check("spurious_done", 1, 0);
                end else begin
                    e = q.pop_front();
                    check("C", datapath_out, e.c);
                    check("Z", Z_out, e.z);
                    check("N", N_out, e.n);
                    check("V", V_out, e.v);
                    check("latency", cyc, e.dcyc);
                    @(negedge clk);
                    dbg_addr = RW'(e.rd);
                    #1;
                    check("Rrd", dbg_data, e.rdval);
                end
            end
        end
    end

    initial begin : stim
        int t;
        rst_n = 1'b0; start = 1'b0; dbg_addr = '0;
        randomize_inputs();
        model_reset();
        #12;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_out", datapath_out, 0);
        check("rst_flags", {Z_out, N_out, V_out}, 0);
        check("rst_reg", dbg_data, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // MOVI R0,7; MOVI R1,2; add R2 = R1 + (R0<<1)
        issue(2, 0, 0, 0, 0, 0, 7, 0);
        issue(2, 1, 0, 0, 0, 0, 2, 0);
        issue(0, 2, 1, 0, 1, 0, 0, 0);
        check("t1_out", datapath_out, 16);
        check("t1_flags", {Z_out, N_out, V_out}, 3'b000);
        // CMP R0 - R0
        issue(1, 5, 0, 0, 0, 1, 0, 0);
        check("t2_flags", {Z_out, N_out, V_out}, 3'b100);
        // MOVI -4, MOV ASR1 / LSR1; flags must stay from the CMP
        issue(2, 0, 0, 0, 0, 0, 8'hFC, 0);
        issue(3, 3, 0, 0, 3, 0, 0, 0);
        check("t4_asr", datapath_out, 16'hFFFE);
        check("t4_flags", {Z_out, N_out, V_out}, 3'b100);
        issue(3, 4, 0, 0, 2, 0, 0, 0);
        check("t4_lsr", datapath_out, 16'h7FFE);
        // Build 0x4000 then add to itself: signed overflow
        issue(2, 1, 0, 0, 0, 0, 1, 0);
        for (int i = 0; i < 14; i++) issue(3, 1, 0, 1, 1, 0, 0, 0);
        issue(0, 2, 1, 1, 0, 0, 0, 0);
        check("ovf_out", datapath_out, 16'h8000);
        check("ovf_flags", {Z_out, N_out, V_out}, 3'b011);
        // Start pulsed while busy must be ignored
        issue(0, 6, 2, 1, 0, 1, 0, 1);
        issue(2, 7, 0, 0, 0, 0, 8'h81, 1);

        // Reset during EX of an ALU command targeting R2
        wait_idle("idle_wait");
        mode = 2'b00; rd = 3'd2; rn = 3'd1; rm = 3'd1; shift = 2'b00; aluop = 2'b00;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_out", datapath_out, 0);
        check("abort_flags", {Z_out, N_out, V_out}, 0);
        check("abort_reg", dbg_data, 0);
        q.delete();
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("abort_idle", busy, 0);
        @(negedge clk);
        issue(3, 7, 0, 2, 0, 0, 0, 0);

        for (int i = 0; i < 150; i++) begin
            issue(int'($urandom_range(0, 3)), int'($urandom_range(0, NR-1)),
                  int'($urandom_range(0, NR-1)), int'($urandom_range(0, NR-1)),
                  int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                  int'($urandom_range(0, 255)), ($urandom_range(0, 3) == 0));
        end

        t = 0;
        while (q.size() != 0 && t < 20) begin
            @(negedge clk);
            t++;
        end
        repeat (3) @(negedge clk);
        check("drain", q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
